// File: rtl/tmds_serdes_sequencer_if.sv
// Signal bundle between the TMDS encoders, the sequencer and the OSERDESE2 pair.
// Optional lock_loss_cnt exists only when LOCK_LOSS_COUNT_EN is defined.
interface tmds_serdes_sequencer_if #(
    parameter int NUM_CHANNELS = 3
);
    logic                         mmcm_locked;
    logic                         restart;
    logic [NUM_CHANNELS-1:0][9:0] tmds_in;
    logic [NUM_CHANNELS-1:0][9:0] tmds_out;
    logic                         serdes_rst;
    logic                         video_ready;
    logic [2:0]                   state_dbg;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0]                   lock_loss_cnt;
`endif

    modport master (
        input  mmcm_locked, restart, tmds_in,
`ifdef LOCK_LOSS_COUNT_EN
        output lock_loss_cnt,
`endif
        output tmds_out, serdes_rst, video_ready, state_dbg
    );

    modport slave (
        output mmcm_locked, restart, tmds_in,
`ifdef LOCK_LOSS_COUNT_EN
        input  lock_loss_cnt,
`endif
        input  tmds_out, serdes_rst, video_ready, state_dbg
    );
endinterface

// File: rtl/tmds_serdes_sequencer.sv
// Start-up/recovery sequencer for the per-channel 10:1 TMDS serializers.
// Define LOCK_LOSS_COUNT_EN to add a saturating RUN lock-loss counter.
module tmds_serdes_sequencer #(
    parameter int         NUM_CHANNELS  = 3,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         RST_CYCLES    = 8,
    parameter int         WARMUP_CYCLES = 16,
    parameter logic [9:0] IDLE_SYMBOL   = 10'b1101010100
) (
    input  logic                            i_clk_pixel,
    input  logic                            i_reset,
    tmds_serdes_sequencer_if.master         bus
);
    localparam int MAX_CYC = (SETTLE_CYCLES > RST_CYCLES)
                           ? ((SETTLE_CYCLES > WARMUP_CYCLES) ? SETTLE_CYCLES : WARMUP_CYCLES)
                           : ((RST_CYCLES > WARMUP_CYCLES) ? RST_CYCLES : WARMUP_CYCLES);
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_LOCK_SETTLE = 3'd1,
        ST_SERDES_RST  = 3'd2,
        ST_WARMUP      = 3'd3,
        ST_RUN         = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             w_cnt_next;
    logic                         r_lock_meta;
    logic                         r_lock_s;
    logic                         r_serdes_rst;
    logic                         r_video_ready;
    logic [NUM_CHANNELS-1:0][9:0] r_tmds_out;

    // mmcm_locked is asynchronous to clk_pixel
    always_ff @(posedge i_clk_pixel or posedge i_reset) begin
        if (i_reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= bus.mmcm_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt + 1'b1;
        if (!r_lock_s) begin
            w_next     = ST_WAIT_LOCK;
            w_cnt_next = '0;
        end else if (bus.restart && (r_state == ST_LOCK_SETTLE ||
                                     r_state == ST_WARMUP || r_state == ST_RUN)) begin
            w_next     = ST_SERDES_RST;
            w_cnt_next = '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    w_next     = ST_LOCK_SETTLE;
                    w_cnt_next = '0;
                end
                ST_LOCK_SETTLE: if (r_cnt == SETTLE_LAST) begin
                    w_next     = ST_SERDES_RST;
                    w_cnt_next = '0;
                end
                ST_SERDES_RST: if (r_cnt == RST_LAST) begin
                    w_next     = ST_WARMUP;
                    w_cnt_next = '0;
                end
                ST_WARMUP: if (r_cnt == WARMUP_LAST) begin
                    w_next     = ST_RUN;
                    w_cnt_next = '0;
                end
                ST_RUN: w_cnt_next = '0;
                default: begin
                    w_next     = ST_WAIT_LOCK;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change with the state register
    always_ff @(posedge i_clk_pixel or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_WAIT_LOCK;
            r_cnt         <= '0;
            r_serdes_rst  <= 1'b1;
            r_video_ready <= 1'b0;
            r_tmds_out    <= {NUM_CHANNELS{IDLE_SYMBOL}};
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt_next;
            r_serdes_rst  <= (w_next != ST_WARMUP) && (w_next != ST_RUN);
            r_video_ready <= (w_next == ST_RUN);
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_tmds_out[ch] <= (w_next == ST_RUN) ? bus.tmds_in[ch] : IDLE_SYMBOL;
            end
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] r_lock_loss_cnt;

    // RUN is only reachable with lock_s high, so lock_s low in RUN is a 1->0 edge
    always_ff @(posedge i_clk_pixel or posedge i_reset) begin
        if (i_reset) begin
            r_lock_loss_cnt <= 8'd0;
        end else if (r_state == ST_RUN && !r_lock_s && r_lock_loss_cnt != 8'hFF) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = r_lock_loss_cnt;
`endif

    assign bus.tmds_out    = r_tmds_out;
    assign bus.serdes_rst  = r_serdes_rst;
    assign bus.video_ready = r_video_ready;
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_tmds_serdes_sequencer.sv
// Directed bench for tmds_serdes_sequencer with SETTLE=4, RST=2, WARMUP=3.
module tb_tmds_serdes_sequencer;
    localparam logic [9:0]  IDLE = 10'h354;
    localparam logic [29:0] ALL_IDLE = {IDLE, IDLE, IDLE};

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    tmds_serdes_sequencer_if #(.NUM_CHANNELS(3)) bus ();

    tmds_serdes_sequencer #(
        .NUM_CHANNELS (3),
        .SETTLE_CYCLES(4),
        .RST_CYCLES   (2),
        .WARMUP_CYCLES(3),
        .IDLE_SYMBOL  (10'b1101010100)
    ) dut (
        .i_clk_pixel(clk),
        .i_reset    (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bring-up profile: edge k counted from the first edge that samples mmcm_locked=1
    task automatic check_bringup(input string tag);
        logic [2:0]  exp_st;
        logic [29:0] exp_out;
        for (int k = 0; k <= 11; k++) begin
            step();
            exp_st  = (k < 2) ? 3'd0 : (k < 6) ? 3'd1 : (k < 8) ? 3'd2 : (k < 11) ? 3'd3 : 3'd4;
            exp_out = (k < 11) ? ALL_IDLE : bus.tmds_in;
            n_tests++;
            if (bus.state_dbg !== exp_st) begin
                n_fail++;
                $display("FAIL %s state k=%0d: got %0d want %0d", tag, k, bus.state_dbg, exp_st);
            end
            n_tests++;
            if (bus.serdes_rst !== (k < 8)) begin
                n_fail++;
                $display("FAIL %s serdes_rst k=%0d: got %b want %b", tag, k, bus.serdes_rst, (k < 8));
            end
            n_tests++;
            if (bus.video_ready !== (k >= 11)) begin
                n_fail++;
                $display("FAIL %s video_ready k=%0d: got %b want %b", tag, k, bus.video_ready, (k >= 11));
            end
            n_tests++;
            if (bus.tmds_out !== exp_out) begin
                n_fail++;
                $display("FAIL %s tmds_out k=%0d: got %h want %h", tag, k, bus.tmds_out, exp_out);
            end
        end
    endtask

    task automatic wait_run(input string tag);
        int cyc;
        cyc = 0;
        while (bus.video_ready !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        if (bus.video_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s wait_run timeout: video_ready=%b want 1", tag, bus.video_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mmcm_locked = 1'b1;
        bus.restart = 1'b0;
        bus.tmds_in[0] = 10'h1AB;
        bus.tmds_in[1] = 10'h2CD;
        bus.tmds_in[2] = 10'h0F0;
        #2;
        n_tests++;
        if (bus.state_dbg !== 3'd0 || bus.serdes_rst !== 1'b1 || bus.video_ready !== 1'b0 ||
            bus.tmds_out !== ALL_IDLE) begin
            n_fail++;
            $display("FAIL reset_values: st=%0d rst=%b vr=%b out=%h want 0/1/0/%h",
                     bus.state_dbg, bus.serdes_rst, bus.video_ready, bus.tmds_out, ALL_IDLE);
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_power_up();
        check_bringup("power_up");
    endtask

    task automatic test_pass_through();
        logic [9:0]  vec [3][3];
        logic [29:0] exp_out;
        vec[0] = '{10'h1AB, 10'h2CD, 10'h0F0};
        vec[1] = '{10'h3FF, 10'h000, 10'h155};
        vec[2] = '{10'h354, 10'h0AB, 10'h2AA};
        for (int v = 0; v < 3; v++) begin
            for (int ch = 0; ch < 3; ch++) bus.tmds_in[ch] = vec[v][ch];
            exp_out = {vec[v][2], vec[v][1], vec[v][0]};
            step();
            n_tests++;
            if (bus.tmds_out !== exp_out) begin
                n_fail++;
                $display("FAIL pass_through v=%0d: got %h want %h", v, bus.tmds_out, exp_out);
            end
        end
    endtask

    task automatic test_lock_loss();
        bus.mmcm_locked = 1'b0;
        step();
        step();
        n_tests++;
        if (bus.video_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_loss N+1 video_ready: got %b want 1", bus.video_ready);
        end
        step();
        n_tests++;
        if (bus.video_ready !== 1'b0 || bus.serdes_rst !== 1'b1 || bus.tmds_out !== ALL_IDLE) begin
            n_fail++;
            $display("FAIL lock_loss N+2: vr=%b rst=%b out=%h want 0/1/%h",
                     bus.video_ready, bus.serdes_rst, bus.tmds_out, ALL_IDLE);
        end
        step();
        n_tests++;
        if (bus.state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL lock_loss N+3 state: got %0d want 0", bus.state_dbg);
        end
        bus.mmcm_locked = 1'b1;
        check_bringup("relock");
    endtask

    task automatic test_restart();
        logic [2:0] exp_st;
        bus.restart = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            step();
            // second pulse lands on SERDES_RST and must be ignored
            bus.restart = (j == 0);
            exp_st = (j < 2) ? 3'd2 : (j < 5) ? 3'd3 : 3'd4;
            n_tests++;
            if (bus.state_dbg !== exp_st || bus.serdes_rst !== (j < 2) || bus.video_ready !== (j == 5)) begin
                n_fail++;
                $display("FAIL restart j=%0d: st=%0d rst=%b vr=%b want %0d/%b/%b",
                         j, bus.state_dbg, bus.serdes_rst, bus.video_ready, exp_st, (j < 2), (j == 5));
            end
        end
        bus.restart = 1'b0;
    endtask

    task automatic test_simultaneous();
        bus.mmcm_locked = 1'b0;
        step();
        step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        n_tests++;
        if (bus.state_dbg !== 3'd0 || bus.serdes_rst !== 1'b1 || bus.video_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL simultaneous: st=%0d rst=%b vr=%b want 0/1/0",
                     bus.state_dbg, bus.serdes_rst, bus.video_ready);
        end
        bus.mmcm_locked = 1'b1;
        check_bringup("simul_relock");
    endtask

    task automatic test_async_reset();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.state_dbg !== 3'd0 || bus.serdes_rst !== 1'b1 || bus.video_ready !== 1'b0 ||
            bus.tmds_out !== ALL_IDLE) begin
            n_fail++;
            $display("FAIL async_reset: st=%0d rst=%b vr=%b out=%h want 0/1/0/%h",
                     bus.state_dbg, bus.serdes_rst, bus.video_ready, bus.tmds_out, ALL_IDLE);
        end
        step();
        rst = 1'b0;
        check_bringup("after_reset");
    endtask

`ifdef LOCK_LOSS_COUNT_EN
    task automatic test_lock_loss_count();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (bus.lock_loss_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL llc_reset: got %0d want 0", bus.lock_loss_cnt);
        end
        wait_run("llc_first");
        bus.mmcm_locked = 1'b0;
        repeat (3) step();
        n_tests++;
        if (bus.lock_loss_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL llc_one: got %0d want 1", bus.lock_loss_cnt);
        end
        bus.mmcm_locked = 1'b1;
        repeat (7) step();
        bus.mmcm_locked = 1'b0;
        step();
        step();
        n_tests++;
        if (bus.state_dbg !== 3'd3) begin
            n_fail++;
            $display("FAIL llc_warmup_state: got %0d want 3", bus.state_dbg);
        end
        repeat (3) step();
        n_tests++;
        if (bus.lock_loss_cnt !== 8'd1 || bus.state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL llc_warmup_loss: cnt=%0d st=%0d want 1/0", bus.lock_loss_cnt, bus.state_dbg);
        end
        bus.mmcm_locked = 1'b1;
        wait_run("llc_rearm");
        for (int e = 0; e < 299; e++) begin
            bus.mmcm_locked = 1'b0;
            repeat (3) step();
            bus.mmcm_locked = 1'b1;
            wait_run("llc_loop");
        end
        n_tests++;
        if (bus.lock_loss_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL llc_saturate: got %0d want 255", bus.lock_loss_cnt);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_power_up();
        test_pass_through();
        test_lock_loss();
        test_restart();
        test_simultaneous();
        test_async_reset();
`ifdef LOCK_LOSS_COUNT_EN
        test_lock_loss_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
